// File: rtl/miriscv_rvfi_retire_buffer_if.sv
// Retirement packet bus into the RVFI retire buffer and the NRET-wide RVFI trace bus out of it.
interface miriscv_rvfi_retire_buffer_if #(
  parameter int XLEN = 32,
  parameter int NRET = 2
);
  logic                 w_valid_i;
  logic                 w_ready_o;
  logic [31:0]          w_insn_i;
  logic [XLEN-1:0]      w_pc_rdata_i;
  logic [XLEN-1:0]      w_pc_wdata_i;
  logic                 w_wb_we_i;
  logic [4:0]           w_rd_addr_i;
  logic [XLEN-1:0]      w_rd_wdata_i;
  logic                 w_mem_req_i;
  logic                 w_mem_we_i;
  logic [2:0]           w_mem_size_i;
  logic [XLEN-1:0]      w_mem_addr_i;
  logic [XLEN-1:0]      w_mem_rdata_i;
  logic [XLEN-1:0]      w_mem_wdata_i;
  logic                 w_trap_i;
  logic                 w_intr_i;

  logic [NRET-1:0]      rvfi_valid_o;
  logic [64*NRET-1:0]   rvfi_order_o;
  logic [32*NRET-1:0]   rvfi_insn_o;
  logic [32*NRET-1:0]   rvfi_pc_rdata_o;
  logic [32*NRET-1:0]   rvfi_pc_wdata_o;
  logic [5*NRET-1:0]    rvfi_rd_addr_o;
  logic [32*NRET-1:0]   rvfi_rd_wdata_o;
  logic [32*NRET-1:0]   rvfi_mem_addr_o;
  logic [4*NRET-1:0]    rvfi_mem_rmask_o;
  logic [4*NRET-1:0]    rvfi_mem_wmask_o;
  logic [32*NRET-1:0]   rvfi_mem_rdata_o;
  logic [32*NRET-1:0]   rvfi_mem_wdata_o;
  logic [NRET-1:0]      rvfi_trap_o;
  logic [NRET-1:0]      rvfi_intr_o;

  // Buffer side: consumes retirement packets, produces the RVFI channels.
  modport slave (
    input  w_valid_i, w_insn_i, w_pc_rdata_i, w_pc_wdata_i, w_wb_we_i, w_rd_addr_i,
           w_rd_wdata_i, w_mem_req_i, w_mem_we_i, w_mem_size_i, w_mem_addr_i,
           w_mem_rdata_i, w_mem_wdata_i, w_trap_i, w_intr_i,
    output w_ready_o, rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_rdata_o,
           rvfi_pc_wdata_o, rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_mem_addr_o,
           rvfi_mem_rmask_o, rvfi_mem_wmask_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o,
           rvfi_trap_o, rvfi_intr_o
  );

  modport master (
    output w_valid_i, w_insn_i, w_pc_rdata_i, w_pc_wdata_i, w_wb_we_i, w_rd_addr_i,
           w_rd_wdata_i, w_mem_req_i, w_mem_we_i, w_mem_size_i, w_mem_addr_i,
           w_mem_rdata_i, w_mem_wdata_i, w_trap_i, w_intr_i,
    input  w_ready_o, rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_pc_rdata_o,
           rvfi_pc_wdata_o, rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_mem_addr_o,
           rvfi_mem_rmask_o, rvfi_mem_wmask_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o,
           rvfi_trap_o, rvfi_intr_o
  );
endinterface

// File: rtl/miriscv_rvfi_retire_buffer.sv
// Buffers one normalised retirement packet per cycle in a DEPTH-entry FIFO and
// drains up to NRET packets per cycle onto registered RVFI channels with a 64-bit order.
module miriscv_rvfi_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int NRET  = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       drain_en_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  miriscv_rvfi_retire_buffer_if.slave rvfi_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      rmask;
    logic [3:0]      wmask;
    logic            trap;
    logic            intr;
  } pkt_t;

  pkt_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   order_q;

  logic [NRET-1:0] valid_q;
  pkt_t            out_q       [NRET];
  logic [63:0]     out_order_q [NRET];

  logic          push;
  logic [CW-1:0] n_pop;
  logic [3:0]    base_mask;
  pkt_t          push_pkt;

  // Readiness depends on current occupancy only; a same-edge pop never frees a slot.
  assign rvfi_if.w_ready_o = (count_q < CW'(DEPTH));
  assign push              = rvfi_if.w_valid_i && rvfi_if.w_ready_o && !flush_i;
  assign fifo_count_o      = count_q;

  always_comb begin
    n_pop = '0;
    if (drain_en_i && !flush_i)
      n_pop = (count_q > CW'(NRET)) ? CW'(NRET) : count_q;
  end

  assign count_d = count_q + CW'(push) - n_pop;

  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    base_mask = 4'b0000;
    unique casez (rvfi_if.w_mem_size_i)
      3'b?00:  base_mask = 4'b0001 << rvfi_if.w_mem_addr_i[1:0];
      3'b?01:  base_mask = 4'b0011 << {rvfi_if.w_mem_addr_i[1], 1'b0};
      3'b?10:  base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase

    push_pkt           = '0;
    push_pkt.insn      = rvfi_if.w_insn_i;
    push_pkt.pc_rdata  = rvfi_if.w_pc_rdata_i;
    push_pkt.pc_wdata  = rvfi_if.w_pc_wdata_i;
    push_pkt.rd_addr   = rvfi_if.w_wb_we_i ? rvfi_if.w_rd_addr_i : 5'd0;
    push_pkt.rd_wdata  = (push_pkt.rd_addr == 5'd0) ? '0 : rvfi_if.w_rd_wdata_i;
    push_pkt.mem_addr  = rvfi_if.w_mem_addr_i;
    push_pkt.mem_rdata = rvfi_if.w_mem_rdata_i;
    push_pkt.mem_wdata = rvfi_if.w_mem_wdata_i;
    push_pkt.trap      = rvfi_if.w_trap_i;
    push_pkt.intr      = rvfi_if.w_intr_i;
    if (rvfi_if.w_mem_req_i && !rvfi_if.w_trap_i) begin
      push_pkt.rmask = rvfi_if.w_mem_we_i ? 4'b0000 : base_mask;
      push_pkt.wmask = rvfi_if.w_mem_we_i ? base_mask : 4'b0000;
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count_q, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_pkt;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      order_q  <= '0;
      valid_q  <= '0;
      for (int k = 0; k < NRET; k++) begin
        out_q[k]       <= '0;
        out_order_q[k] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_q + PW'(n_pop);
      count_q  <= count_d;
      order_q  <= order_q + 64'(n_pop);
      // Unused channels drop valid but keep their last payload.
      for (int k = 0; k < NRET; k++) begin
        if (CW'(k) < n_pop) begin
          valid_q[k]     <= 1'b1;
          out_q[k]       <= mem_q[rd_ptr_q + PW'(k)];
          out_order_q[k] <= order_q + 64'(k);
        end else begin
          valid_q[k]     <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rvfi_if.rvfi_valid_o     = valid_q;
    rvfi_if.rvfi_order_o     = '0;
    rvfi_if.rvfi_insn_o      = '0;
    rvfi_if.rvfi_pc_rdata_o  = '0;
    rvfi_if.rvfi_pc_wdata_o  = '0;
    rvfi_if.rvfi_rd_addr_o   = '0;
    rvfi_if.rvfi_rd_wdata_o  = '0;
    rvfi_if.rvfi_mem_addr_o  = '0;
    rvfi_if.rvfi_mem_rmask_o = '0;
    rvfi_if.rvfi_mem_wmask_o = '0;
    rvfi_if.rvfi_mem_rdata_o = '0;
    rvfi_if.rvfi_mem_wdata_o = '0;
    rvfi_if.rvfi_trap_o      = '0;
    rvfi_if.rvfi_intr_o      = '0;
    for (int k = 0; k < NRET; k++) begin
      rvfi_if.rvfi_order_o[k*64 +: 64]    = out_order_q[k];
      rvfi_if.rvfi_insn_o[k*32 +: 32]     = out_q[k].insn;
      rvfi_if.rvfi_pc_rdata_o[k*32 +: 32] = out_q[k].pc_rdata;
      rvfi_if.rvfi_pc_wdata_o[k*32 +: 32] = out_q[k].pc_wdata;
      rvfi_if.rvfi_rd_addr_o[k*5 +: 5]    = out_q[k].rd_addr;
      rvfi_if.rvfi_rd_wdata_o[k*32 +: 32] = out_q[k].rd_wdata;
      rvfi_if.rvfi_mem_addr_o[k*32 +: 32] = out_q[k].mem_addr;
      rvfi_if.rvfi_mem_rmask_o[k*4 +: 4]  = out_q[k].rmask;
      rvfi_if.rvfi_mem_wmask_o[k*4 +: 4]  = out_q[k].wmask;
      rvfi_if.rvfi_mem_rdata_o[k*32 +: 32] = out_q[k].mem_rdata;
      rvfi_if.rvfi_mem_wdata_o[k*32 +: 32] = out_q[k].mem_wdata;
      rvfi_if.rvfi_trap_o[k]              = out_q[k].trap;
      rvfi_if.rvfi_intr_o[k]              = out_q[k].intr;
    end
  end

endmodule

// File: tb/tb_miriscv_rvfi_retire_buffer.sv
// Directed self-checking bench for miriscv_rvfi_retire_buffer (DEPTH=4, NRET=2).
module tb_miriscv_rvfi_retire_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int NRET  = 2;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       drain_en_i;
  logic       flush_i;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  miriscv_rvfi_retire_buffer_if #(.XLEN(XLEN), .NRET(NRET)) bus ();

  miriscv_rvfi_retire_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NRET(NRET)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .drain_en_i   (drain_en_i),
    .flush_i      (flush_i),
    .fifo_count_o (fifo_count),
    .rvfi_if      (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] insn,
                       input logic wb_we = 1'b0, input logic [4:0] rd = 5'd0,
                       input logic [31:0] rd_data = 32'h0, input logic req = 1'b0,
                       input logic we = 1'b0, input logic [2:0] size = 3'd0,
                       input logic [31:0] addr = 32'h0, input logic trap = 1'b0);
    bus.w_valid_i     = v;
    bus.w_insn_i      = insn;
    bus.w_pc_rdata_i  = {insn[15:0], 16'h0000};
    bus.w_pc_wdata_i  = {insn[15:0], 16'h0004};
    bus.w_wb_we_i     = wb_we;
    bus.w_rd_addr_i   = rd;
    bus.w_rd_wdata_i  = rd_data;
    bus.w_mem_req_i   = req;
    bus.w_mem_we_i    = we;
    bus.w_mem_size_i  = size;
    bus.w_mem_addr_i  = addr;
    bus.w_mem_rdata_i = 32'hDEAD_0000;
    bus.w_mem_wdata_i = 32'hBEEF_0000;
    bus.w_trap_i      = trap;
    bus.w_intr_i      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Push one packet into an empty buffer with drain enabled; it shows on channel 0 one edge later.
  task automatic retire(input logic [31:0] insn, input logic wb_we, input logic [4:0] rd,
                        input logic [31:0] rd_data, input logic req, input logic we,
                        input logic [2:0] size, input logic [31:0] addr, input logic trap);
    drive(1'b1, insn, wb_we, rd, rd_data, req, we, size, addr, trap);
    step();
    drive(1'b0, 32'h0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i     = 1'b1;
    drain_en_i = 1'b0;
    flush_i    = 1'b0;
    drive(1'b0, 32'h0);
    #12;
    check("rst_valid", 64'(bus.rvfi_valid_o), 64'h0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_order1", bus.rvfi_order_o[127:64], 64'd0);
    check("rst_insn0", 64'(bus.rvfi_insn_o[31:0]), 64'h0);
    arst_i = 1'b0;
    #1;
    check("rst_ready", 64'(bus.w_ready_o), 64'd1);

    // Three pushes held, then drained two-wide.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i));
      step();
      check($sformatf("t1_count%0d", i), 64'(fifo_count), 64'(i + 1));
      check($sformatf("t1_ready%0d", i), 64'(bus.w_ready_o), 64'd1);
    end
    drive(1'b0, 32'h0);
    drain_en_i = 1'b1;
    step();
    check("t1_valid_a", 64'(bus.rvfi_valid_o), 64'b11);
    check("t1_order0_a", bus.rvfi_order_o[63:0], 64'd0);
    check("t1_order1_a", bus.rvfi_order_o[127:64], 64'd1);
    check("t1_insn0_a", 64'(bus.rvfi_insn_o[31:0]), 64'hA0);
    check("t1_insn1_a", 64'(bus.rvfi_insn_o[63:32]), 64'hA1);
    check("t1_count_a", 64'(fifo_count), 64'd1);
    step();
    check("t1_valid_b", 64'(bus.rvfi_valid_o), 64'b01);
    check("t1_order0_b", bus.rvfi_order_o[63:0], 64'd2);
    check("t1_insn0_b", 64'(bus.rvfi_insn_o[31:0]), 64'hA2);
    check("t1_order1_hold", bus.rvfi_order_o[127:64], 64'd1);
    check("t1_count_b", 64'(fifo_count), 64'd0);
    step();
    check("t1_valid_c", 64'(bus.rvfi_valid_o), 64'b00);

    // Five pushes into a four-entry buffer: the fifth is ignored.
    drain_en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hB0 + 32'(i));
      step();
      check($sformatf("t2_count%0d", i), 64'(fifo_count), 64'((i < 4) ? i + 1 : 4));
      check($sformatf("t2_ready%0d", i), 64'(bus.w_ready_o), 64'((i < 3) ? 1 : 0));
    end
    drive(1'b0, 32'h0);
    drain_en_i = 1'b1;
    step();
    check("t2_valid_a", 64'(bus.rvfi_valid_o), 64'b11);
    check("t2_insn0_a", 64'(bus.rvfi_insn_o[31:0]), 64'hB0);
    check("t2_insn1_a", 64'(bus.rvfi_insn_o[63:32]), 64'hB1);
    check("t2_order0_a", bus.rvfi_order_o[63:0], 64'd3);
    check("t2_order1_a", bus.rvfi_order_o[127:64], 64'd4);
    step();
    check("t2_valid_b", 64'(bus.rvfi_valid_o), 64'b11);
    check("t2_insn0_b", 64'(bus.rvfi_insn_o[31:0]), 64'hB2);
    check("t2_insn1_b", 64'(bus.rvfi_insn_o[63:32]), 64'hB3);
    check("t2_order1_b", bus.rvfi_order_o[127:64], 64'd6);
    check("t2_count_b", 64'(fifo_count), 64'd0);
    step();
    check("t2_valid_c", 64'(bus.rvfi_valid_o), 64'b00);

    // Field normalisation; drain stays enabled, order continues from 7.
    retire(32'hC0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd0, 32'h0000_1003, 1'b0);
    check("sb_valid", 64'(bus.rvfi_valid_o), 64'b01);
    check("sb_order", bus.rvfi_order_o[63:0], 64'd7);
    check("sb_wmask", 64'(bus.rvfi_mem_wmask_o[3:0]), 64'b1000);
    check("sb_rmask", 64'(bus.rvfi_mem_rmask_o[3:0]), 64'b0000);
    check("sb_addr", 64'(bus.rvfi_mem_addr_o[31:0]), 64'h0000_1003);
    retire(32'hC1, 1'b1, 5'd3, 32'h55, 1'b1, 1'b0, 3'd5, 32'h0000_2002, 1'b0);
    check("lhu_rmask", 64'(bus.rvfi_mem_rmask_o[3:0]), 64'b1100);
    check("lhu_wmask", 64'(bus.rvfi_mem_wmask_o[3:0]), 64'b0000);
    check("lhu_order", bus.rvfi_order_o[63:0], 64'd8);
    retire(32'hC2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 3'd2, 32'h0000_3000, 1'b0);
    check("sw_wmask", 64'(bus.rvfi_mem_wmask_o[3:0]), 64'b1111);
    retire(32'hC3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 3'd2, 32'h0000_4000, 1'b1);
    check("trap_rmask", 64'(bus.rvfi_mem_rmask_o[3:0]), 64'b0000);
    check("trap_wmask", 64'(bus.rvfi_mem_wmask_o[3:0]), 64'b0000);
    check("trap_flag", 64'(bus.rvfi_trap_o[0]), 64'd1);
    check("trap_order", bus.rvfi_order_o[63:0], 64'd10);
    retire(32'hC4, 1'b0, 5'd7, 32'h1234, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    check("nowe_rd", 64'(bus.rvfi_rd_addr_o[4:0]), 64'd0);
    check("nowe_wdata", 64'(bus.rvfi_rd_wdata_o[31:0]), 64'h0);
    check("nowe_trap", 64'(bus.rvfi_trap_o[0]), 64'd0);
    retire(32'hC5, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    check("x0_wdata", 64'(bus.rvfi_rd_wdata_o[31:0]), 64'h0);
    retire(32'hC6, 1'b1, 5'd5, 32'hABCD, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    check("wb_rd", 64'(bus.rvfi_rd_addr_o[4:0]), 64'd5);
    check("wb_wdata", 64'(bus.rvfi_rd_wdata_o[31:0]), 64'hABCD);
    check("wb_order", bus.rvfi_order_o[63:0], 64'd13);
    retire(32'hC7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 3'd4, 32'h0000_5001, 1'b0);
    check("lbu_rmask", 64'(bus.rvfi_mem_rmask_o[3:0]), 64'b0010);
    check("lbu_order", bus.rvfi_order_o[63:0], 64'd14);

    // Fresh reset, then 100 cycles of continuous push with drain.
    #2 arst_i = 1'b1;
    #2 arst_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h1000 + 32'(i));
      step();
      if (i > 0) begin
        check($sformatf("s_valid%0d", i), 64'(bus.rvfi_valid_o), 64'b01);
        check($sformatf("s_order%0d", i), bus.rvfi_order_o[63:0], 64'(i - 1));
        check($sformatf("s_insn%0d", i), 64'(bus.rvfi_insn_o[31:0]), 64'(32'h1000 + 32'(i - 1)));
      end
      check($sformatf("s_count%0d", i), 64'(fifo_count), 64'd1);
    end
    drive(1'b0, 32'h0);
    step();
    check("s_valid_last", 64'(bus.rvfi_valid_o), 64'b01);
    check("s_order_last", bus.rvfi_order_o[63:0], 64'd99);
    check("s_insn_last", 64'(bus.rvfi_insn_o[31:0]), 64'h1063);
    check("s_count_last", 64'(fifo_count), 64'd0);

    // Flush with three entries buffered and a packet presented on the same edge.
    drain_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD0 + 32'(i));
      step();
    end
    check("fl_count_pre", 64'(fifo_count), 64'd3);
    drive(1'b1, 32'hEE);
    flush_i    = 1'b1;
    drain_en_i = 1'b1;
    step();
    check("fl_count", 64'(fifo_count), 64'd0);
    check("fl_valid", 64'(bus.rvfi_valid_o), 64'b00);
    flush_i = 1'b0;
    drive(1'b0, 32'h0);
    step();
    check("fl_count_after", 64'(fifo_count), 64'd0);
    check("fl_valid_after", 64'(bus.rvfi_valid_o), 64'b00);
    retire(32'hE0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    check("fl_next_valid", 64'(bus.rvfi_valid_o), 64'b01);
    check("fl_next_order", bus.rvfi_order_o[63:0], 64'd100);
    check("fl_next_insn", 64'(bus.rvfi_insn_o[31:0]), 64'hE0);

    // Reset asserted between edges while draining.
    drain_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF0 + 32'(i));
      step();
    end
    drive(1'b0, 32'h0);
    drain_en_i = 1'b1;
    step();
    check("mr_valid_pre", 64'(bus.rvfi_valid_o), 64'b11);
    check("mr_order1_pre", bus.rvfi_order_o[127:64], 64'd102);
    #2 arst_i = 1'b1;
    #1;
    check("mr_valid", 64'(bus.rvfi_valid_o), 64'b00);
    check("mr_order0", bus.rvfi_order_o[63:0], 64'd0);
    check("mr_order1", bus.rvfi_order_o[127:64], 64'd0);
    check("mr_insn0", 64'(bus.rvfi_insn_o[31:0]), 64'h0);
    check("mr_count", 64'(fifo_count), 64'd0);
    #2 arst_i = 1'b0;
    #1;
    check("mr_ready", 64'(bus.w_ready_o), 64'd1);
    step();
    check("mr_valid_post", 64'(bus.rvfi_valid_o), 64'b00);
    retire(32'hF9, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    check("mr_next_order", bus.rvfi_order_o[63:0], 64'd0);
    check("mr_next_insn", 64'(bus.rvfi_insn_o[31:0]), 64'hF9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_rvfi_retire_buffer.md
Name: miriscv_rvfi_retire_buffer

Overview:
- Parametrised successor to the single-retire RVFI controller.
- Accepts at most one retired-instruction packet per cycle from the writeback boundary and buffers it in a DEPTH-entry FIFO.
- Drains up to NRET packets per cycle onto NRET registered RVFI channels, tracking a 64-bit retirement order.
- Sits between the core's writeback-side RVFI signals and the formal/trace harness, and provides backpressure when full.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- DEPTH, 4, FIFO entries; must be a power of two and ≥ 2.
- NRET, 2, RVFI channels per cycle; 1 ≤ NRET ≤ DEPTH.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous, active-high reset.
- w_valid_i  in  1  a retirement packet is presented.
- w_ready_o  out  1  buffer can accept a packet this cycle.
- w_insn_i  in  32  instruction word.
- w_pc_rdata_i  in  XLEN  PC of the instruction.
- w_pc_wdata_i  in  XLEN  next PC.
- w_wb_we_i  in  1  GPR write enable.
- w_rd_addr_i  in  5  destination register.
- w_rd_wdata_i  in  XLEN  writeback data.
- w_mem_req_i  in  1  memory access.
- w_mem_we_i  in  1  store when 1, load when 0.
- w_mem_size_i  in  3  funct3 size code.
- w_mem_addr_i  in  XLEN  memory address.
- w_mem_rdata_i  in  XLEN  load data.
- w_mem_wdata_i  in  XLEN  store data.
- w_trap_i  in  1  trap flag.
- w_intr_i  in  1  interrupt flag.
- drain_en_i  in  1  harness permits output this cycle.
- flush_i  in  1  discard all buffered packets.
- rvfi_valid_o  out  NRET  per-channel valid.
- rvfi_order_o  out  64*NRET  retirement order.
- rvfi_insn_o, rvfi_pc_rdata_o, rvfi_pc_wdata_o, rvfi_rd_wdata_o, rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o  out  32*NRET each  as named.
- rvfi_rd_addr_o  out  5*NRET  destination register.
- rvfi_mem_rmask_o, rvfi_mem_wmask_o  out  4*NRET each  byte masks.
- rvfi_trap_o, rvfi_intr_o  out  NRET each  flags.
- fifo_count_o  out  $clog2(DEPTH)+1  occupancy.
- Channel k occupies bits [k*W +: W] of each bus.

Behaviour:
- Reset (arst_i high, asynchronous):
  - FIFO empty; read and write pointers = 0.
  - Order counter = 0.
  - All rvfi_* outputs = 0.
  - fifo_count_o = 0.
  - w_ready_o = 1 once reset is released.
  - Reset asserted mid-drain drops all packets with no partial output.
- Push:
  - A packet is written on a rising edge when w_valid_i && w_ready_o.
  - w_ready_o = (count < DEPTH), computed from current occupancy only; a same-cycle pop never frees space for a same-cycle push.
  - w_valid_i while full is ignored; the producer must stall.
- Field normalisation at push:
  - rd_addr = w_wb_we_i ? w_rd_addr_i : 0.
  - rd_wdata = 0 when the normalised rd_addr == 0.
  - Base byte mask from w_mem_size_i[1:0]:
    - 0 (byte) → 4'b0001 << addr[1:0]
    - 1 (half) → 4'b0011 << {addr[1],1'b0}
    - 2 (word) → 4'b1111
    - 3 → 0
  - w_mem_size_i[2] (unsigned load) does not change the mask.
  - rmask = base mask if mem_req && !mem_we, else 0.
  - wmask = base mask if mem_req && mem_we, else 0.
  - When w_trap_i = 1, both masks are forced to 0.
- Pop:
  - Each edge, n = drain_en_i ? min(count, NRET) : 0 entries are popped in FIFO order.
  - Popped entries go to channels 0..n-1; rvfi_valid_o has only low-contiguous bits set.
  - Channels ≥ n have valid = 0; their other fields hold previous values.
  - Channel k gets order = order_cnt + k.
  - order_cnt advances by n and wraps modulo 2^64.
- Latency:
  - A packet pushed at edge N into an empty buffer appears on the outputs after edge N+1, provided drain_en_i is high at N+1.
  - Outputs are fully registered.
- Count: count_next = count + push − n; fifo_count_o reflects the registered count.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty is decided by count.
- Flush:
  - flush_i high at an edge empties the FIFO, suppresses both push and pop that edge, and drives rvfi_valid_o = 0.
  - The order counter is not changed.
- Simultaneous push and pop: both take effect on the same edge; the pushed entry is never popped at that edge.

Test Plan:
- NRET=2, DEPTH=4; 3 pushes, drain_en_i low, then high → count reaches 3, w_ready_o stays 1; drain gives a cycle with valid=2'b11 and order 0,1, then a cycle with valid=2'b01 and order 2.
- 5 back-to-back pushes with drain_en_i=0 → after 4 pushes w_ready_o=0 and the 5th is ignored; count=4; the drained insn sequence equals the first 4 pushed.
- Byte store at addr 0x...03 → wmask=4'b1000, rmask=0. Halfword load (size=5) at addr 0x...02 → rmask=4'b1100. Trap packet with mem_req=1 → both masks 0.
- w_wb_we_i=0 with rd=7, data 0x1234 → rd_addr=0, rd_wdata=0. wb_we=1, rd=0, data 0xFFFF → rd_wdata=0.
- Continuous push with drain_en_i=1 for 100 cycles → single-channel valid each cycle; order increments 0..99 with no gaps; count ≤ 1.
- Fill 3 entries, then flush_i=1 → count=0 and no valid output; the next packet pushed after the flush retires with order equal to the last retired order + 1. Also, arst_i asserted mid-drain → all outputs 0 immediately.
